// File: rtl/rr_phase_scheduler_if.sv
// -----------------------------------------------------------------------------
// rr_phase_scheduler_if
// Bundles the request/length inputs and the grant/phase outputs of the
// round-robin two-phase scheduler.
//   req     : level request per requester (bit i = requester i)
//   g1_len  : G1 phase length in cycles (0 behaves as 1)
//   g2_len  : G2 phase length in cycles (0 behaves as 1)
//   gnt     : one-hot grant, held for the whole G1+G2 operation
//   out_1   : high while in G1
//   out_2   : high while in G2
//   busy    : high in G1 or G2
//   done    : one-cycle pulse on the final G2 cycle
// master = requesting side, slave = scheduler.
// -----------------------------------------------------------------------------
interface rr_phase_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4
);
  logic [NUM_REQ-1:0] req;
  logic [LEN_W-1:0]   g1_len;
  logic [LEN_W-1:0]   g2_len;
  logic [NUM_REQ-1:0] gnt;
  logic               out_1;
  logic               out_2;
  logic               busy;
  logic               done;

  modport master (
    output req, g1_len, g2_len,
    input  gnt, out_1, out_2, busy, done
  );

  modport slave (
    input  req, g1_len, g2_len,
    output gnt, out_1, out_2, busy, done
  );
endinterface

// File: rtl/rr_phase_scheduler.sv
// -----------------------------------------------------------------------------
// rr_phase_scheduler
// Shares one two-phase sequencer (G1 then G2) among NUM_REQ requesters using
// round-robin arbitration. From IDLE it grants one pending requester, runs G1
// for max(g1_len,1) cycles and G2 for max(g2_len,1) cycles, then releases the
// grant and returns to IDLE for at least one cycle.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : rr_phase_scheduler_if slave (req, g1_len, g2_len in;
//           gnt, out_1, out_2, busy, done out)
// All outputs come straight from flops; req only influences the next state.
// -----------------------------------------------------------------------------
module rr_phase_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4
) (
  input logic                  clock,
  input logic                  reset,
  rr_phase_scheduler_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_G1   = 2'b01,
    S_G2   = 2'b10
  } state_t;

  // Round-robin search: first set request strictly after the last grant, wrapping.
  function automatic logic [PTR_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [PTR_W-1:0]   p
  );
    logic [PTR_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = p;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(p) + i) % NUM_REQ;
      if (!found && r[idx]) begin
        sel   = PTR_W'(idx);
        found = 1'b1;
      end else begin
        sel   = sel;
        found = found;
      end
    end
    return sel;
  endfunction

  // Counter preload: a phase of length L runs the counter from L-1 down to 0;
  // a zero length is treated as one cycle.
  function automatic logic [LEN_W-1:0] len_preload(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] v;
    if (len == {LEN_W{1'b0}}) begin
      v = {LEN_W{1'b0}};
    end else begin
      v = len - LEN_W'(1);
    end
    return v;
  endfunction

  state_t             state_r, state_nx_s;
  logic [LEN_W-1:0]   cnt_r, cnt_nx_s;
  logic [PTR_W-1:0]   ptr_r, ptr_nx_s;
  logic [PTR_W-1:0]   pick_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_nx_s;
  logic               out_1_r, out_1_nx_s;
  logic               out_2_r, out_2_nx_s;
  logic               busy_r, busy_nx_s;
  logic               done_r, done_nx_s;
  logic               cnt_zero_s;

  assign pick_s     = rr_pick(bus.req, ptr_r);
  assign cnt_zero_s = (cnt_r == {LEN_W{1'b0}});

  // Next-state, counter, grant and output decode for the IDLE/G1/G2 sequencer.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    ptr_nx_s   = ptr_r;
    gnt_nx_s   = gnt_r;
    case (state_r)
      S_IDLE: begin
        if (|bus.req) begin
          state_nx_s = S_G1;
          ptr_nx_s   = pick_s;
          gnt_nx_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
          cnt_nx_s   = len_preload(bus.g1_len);
        end else begin
          state_nx_s = S_IDLE;
          gnt_nx_s   = {NUM_REQ{1'b0}};
          cnt_nx_s   = cnt_r;
        end
      end
      S_G1: begin
        if (cnt_zero_s) begin
          state_nx_s = S_G2;
          cnt_nx_s   = len_preload(bus.g2_len);
        end else begin
          state_nx_s = S_G1;
          cnt_nx_s   = cnt_r - LEN_W'(1);
        end
      end
      S_G2: begin
        if (cnt_zero_s) begin
          state_nx_s = S_IDLE;
          gnt_nx_s   = {NUM_REQ{1'b0}};
          cnt_nx_s   = {LEN_W{1'b0}};
        end else begin
          state_nx_s = S_G2;
          cnt_nx_s   = cnt_r - LEN_W'(1);
        end
      end
      default: begin
        state_nx_s = S_IDLE;
        gnt_nx_s   = {NUM_REQ{1'b0}};
        cnt_nx_s   = {LEN_W{1'b0}};
      end
    endcase
    // Outputs are registered from the next state so they line up with state_r.
    out_1_nx_s = (state_nx_s == S_G1);
    out_2_nx_s = (state_nx_s == S_G2);
    busy_nx_s  = out_1_nx_s | out_2_nx_s;
    done_nx_s  = out_2_nx_s && (cnt_nx_s == {LEN_W{1'b0}});
  end

  // State, counter, pointer and registered outputs with asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= {LEN_W{1'b0}};
      ptr_r   <= PTR_W'(NUM_REQ - 1);
      gnt_r   <= {NUM_REQ{1'b0}};
      out_1_r <= 1'b0;
      out_2_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      ptr_r   <= ptr_nx_s;
      gnt_r   <= gnt_nx_s;
      out_1_r <= out_1_nx_s;
      out_2_r <= out_2_nx_s;
      busy_r  <= busy_nx_s;
      done_r  <= done_nx_s;
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.out_1 = out_1_r;
  assign bus.out_2 = out_2_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_rr_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rr_phase_scheduler
// Directed bench for rr_phase_scheduler. Per-cycle vectors hold
// {req, g1_len, g2_len, expected {gnt,out_1,out_2,busy,done}}; multi-cycle
// corners (request withdrawal, reset mid-operation) are hand-written.
// -----------------------------------------------------------------------------
module tb_rr_phase_scheduler;

  localparam int NR = 4;
  localparam int LW = 4;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  rr_phase_scheduler_if #(.NUM_REQ(NR), .LEN_W(LW)) bus ();

  rr_phase_scheduler #(.NUM_REQ(NR), .LEN_W(LW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] g1;
    logic [3:0] g2;
    logic [7:0] exp;   // {gnt[3:0], out_1, out_2, busy, done}
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Output bit patterns (low nibble): G1 phase, G2 phase, G2 final cycle.
  localparam logic [3:0] P_G1   = 4'b1010;
  localparam logic [3:0] P_G2   = 4'b0110;
  localparam logic [3:0] P_DONE = 4'b0111;

  function automatic logic [7:0] obs();
    return {bus.gnt, bus.out_1, bus.out_2, bus.busy, bus.done};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic inv();
    logic bad;
    bad = (bus.out_1 && bus.out_2) || !$onehot0(bus.gnt) ||
          (bus.busy != (bus.gnt != 4'b0000)) || (bus.busy != (bus.out_1 | bus.out_2)) ||
          (bus.done && !bus.out_2);
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL invariant actual=%b required=consistent", obs());
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    inv();
  endtask

  task automatic push(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] e);
    vec_t v;
    v.req = r; v.g1 = a; v.g2 = b; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] g;
    reset      = 1'b0;
    bus.req    = 4'b0000;
    bus.g1_len = 4'd0;
    bus.g2_len = 4'd0;

    // Test 1: reset held for 3 cycles, then released with no requests.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      chk("reset_hold", obs(), 8'h00);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("idle_after_reset", obs(), 8'h00);
    end

    // Test 3: all requesting, 1+1 lengths -> grants 0,1,2,3,0 with an idle gap.
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      push(4'b1111, 4'd1, 4'd1, {g, P_G1});
      push((k == 4) ? 4'b0000 : 4'b1111, 4'd1, 4'd1, {g, P_DONE});
      push((k == 4) ? 4'b0000 : 4'b1111, 4'd1, 4'd1, 8'h00);
    end
    // Test 2: req=0010, G1=2, G2=3; lengths changed mid-phase must not matter.
    push(4'b0010, 4'd2, 4'd3,  {4'b0010, P_G1});
    push(4'b0000, 4'd7, 4'd3,  {4'b0010, P_G1});
    push(4'b0000, 4'd7, 4'd3,  {4'b0010, P_G2});
    push(4'b0000, 4'd7, 4'd15, {4'b0010, P_G2});
    push(4'b0000, 4'd7, 4'd15, {4'b0010, P_DONE});
    push(4'b0000, 4'd7, 4'd15, 8'h00);
    // Test 4: zero lengths behave as one cycle each.
    push(4'b0001, 4'd0, 4'd0, {4'b0001, P_G1});
    push(4'b0000, 4'd0, 4'd0, {4'b0001, P_DONE});
    push(4'b0000, 4'd0, 4'd0, 8'h00);
    push(4'b0000, 4'd0, 4'd0, 8'h00);

    foreach (tbl[i]) begin
      bus.req    = tbl[i].req;
      bus.g1_len = tbl[i].g1;
      bus.g2_len = tbl[i].g2;
      step();
      chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end

    // Test 5: requester 2 withdraws after the first G1 cycle; op still completes.
    bus.req    = 4'b0100;
    bus.g1_len = 4'd4;
    bus.g2_len = 4'd2;
    step();
    chk("wd_g1_0", obs(), {4'b0100, P_G1});
    bus.req    = 4'b0000;
    bus.g1_len = 4'd1;
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("wd_g1_%0d", i), obs(), {4'b0100, P_G1});
    end
    step();
    chk("wd_g2_0", obs(), {4'b0100, P_G2});
    bus.g2_len = 4'd9;
    step();
    chk("wd_g2_done", obs(), {4'b0100, P_DONE});
    step();
    chk("wd_idle", obs(), 8'h00);

    // Test 6: reset asserted during G2 clears outputs asynchronously and the pointer.
    bus.req    = 4'b0001;
    bus.g1_len = 4'd1;
    bus.g2_len = 4'd3;
    step();
    chk("rst_g1", obs(), {4'b0001, P_G1});
    bus.req = 4'b0000;
    step();
    chk("rst_g2", obs(), {4'b0001, P_G2});
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_drop", obs(), 8'h00);
    @(posedge clock);
    #1;
    chk("rst_held", obs(), 8'h00);
    reset      = 1'b1;
    bus.req    = 4'b1001;
    bus.g2_len = 4'd1;
    step();
    chk("rst_ptr_reinit", obs(), {4'b0001, P_G1});
    bus.req = 4'b0000;
    step();
    chk("rst_ptr_g2", obs(), {4'b0001, P_DONE});
    step();
    chk("rst_ptr_idle", obs(), 8'h00);
    bus.req = 4'b1000;
    step();
    chk("req3_grant", obs(), {4'b1000, P_G1});
    bus.req = 4'b0000;
    step();
    chk("req3_done", obs(), {4'b1000, P_DONE});
    step();
    chk("req3_idle", obs(), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
